// File: rtl/prog_mem_if.sv
// Bus bundle between the host loader / fetch stage and the instruction memory.
// The memory owns the slave side; the loader/core side uses master.
interface prog_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  logic              clr_start;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic [ADDR_W:0]   ld_count;
  logic              ld_done;
  logic              clr_done;
  logic              busy;
  logic              rd_en;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              retire;
  logic [ADDR_W-1:0] retire_addr;

  modport slave (
    input  clr_start, ld_start, ld_base, ld_valid, ld_data, ld_last,
    input  rd_en, pc, retire, retire_addr,
    output ld_ready, ld_count, ld_done, clr_done, busy, inst, inst_valid
  );

  modport master (
    output clr_start, ld_start, ld_base, ld_valid, ld_data, ld_last,
    output rd_en, pc, retire, retire_addr,
    input  ld_ready, ld_count, ld_done, clr_done, busy, inst, inst_valid
  );
endinterface

// File: rtl/prog_mem.sv
// Instruction memory with streaming loader, hardware clear sweep, registered
// fetch port and NOP-on-retire. A CLEAR/LOAD/IDLE controller serialises the
// single write port between sweep, loader and retire.
module prog_mem #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 128,
  parameter int                ADDR_W   = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h00001013
) (
  input  logic        clk,
  input  logic        rst,
  prog_mem_if.slave   bus
);

  typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_IDLE} state_e;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_INC  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W:0]   ld_count_q, ld_count_d;
  logic              ld_done_q, ld_done_d;
  logic              clr_done_q, clr_done_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;

  // Array has no reset; its contents are defined only by the clear sweep.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              ld_ready;
  logic              xfer;
  logic              load_end;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Loader handshake is combinational from state and count only.
  assign ld_ready = (state_q == ST_LOAD) && (ld_count_q < FULL_CNT);
  assign xfer     = ld_ready && bus.ld_valid;
  assign load_end = xfer && (bus.ld_last || ((ld_count_q + CNT_INC) == FULL_CNT));

  // State register: reset aborts anything in flight and restarts the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_CLEAR;
    else     state_q <= state_d;
  end

  // Next-state logic: clear request beats load request in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR: if (clr_idx_q == LAST_IDX) state_d = ST_IDLE;
      ST_IDLE: begin
        if (bus.clr_start)     state_d = ST_CLEAR;
        else if (bus.ld_start) state_d = ST_LOAD;
      end
      ST_LOAD:  if (load_end) state_d = ST_IDLE;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Per-state outputs: write-port mux, counters, done pulses and fetch read.
  always_comb begin
    clr_idx_d    = clr_idx_q;
    waddr_d      = waddr_q;
    ld_count_d   = ld_count_q;
    ld_done_d    = 1'b0;
    clr_done_d   = 1'b0;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_idx_q;
        mem_wdata  = '0;
        clr_idx_d  = clr_idx_q + ADDR_INC;
        clr_done_d = (clr_idx_q == LAST_IDX);
      end
      ST_IDLE: begin
        // Read samples the array before this edge's retire write lands.
        if (bus.rd_en) begin
          inst_d       = mem_q[bus.pc];
          inst_valid_d = 1'b1;
        end
        if (bus.retire) begin
          mem_we    = 1'b1;
          mem_waddr = bus.retire_addr;
          mem_wdata = NOP_WORD;
        end
        if (bus.clr_start) begin
          clr_idx_d = '0;
        end else if (bus.ld_start) begin
          waddr_d    = bus.ld_base;
          ld_count_d = '0;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          mem_we     = 1'b1;
          mem_waddr  = waddr_q;
          mem_wdata  = bus.ld_data;
          waddr_d    = waddr_q + ADDR_INC;
          ld_count_d = ld_count_q + CNT_INC;
          ld_done_d  = load_end;
        end
      end
      default: ;
    endcase
  end

  // Control and fetch-output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_idx_q    <= '0;
      waddr_q      <= '0;
      ld_count_q   <= '0;
      ld_done_q    <= 1'b0;
      clr_done_q   <= 1'b0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      clr_idx_q    <= clr_idx_d;
      waddr_q      <= waddr_d;
      ld_count_q   <= ld_count_d;
      ld_done_q    <= ld_done_d;
      clr_done_q   <= clr_done_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Single write port into the storage array.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.ld_ready   = ld_ready;
  assign bus.ld_count   = ld_count_q;
  assign bus.ld_done    = ld_done_q;
  assign bus.clr_done   = clr_done_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;

endmodule

// File: tb/tb_prog_mem.sv
// Scoreboard bench for prog_mem: a word-array reference model supplies the
// expected fetch data, queued at issue time and checked by a monitor.
module tb_prog_mem;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam logic [DATA_W-1:0] NOP = 32'h00001013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  prog_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] mon_exp;
  logic [DATA_W-1:0] wa, wb, wc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.clr_start   = 1'b0;
    bus.ld_start    = 1'b0;
    bus.ld_base     = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_data     = '0;
    bus.ld_last     = 1'b0;
    bus.rd_en       = 1'b0;
    bus.pc          = '0;
    bus.retire      = 1'b0;
    bus.retire_addr = '0;
  endtask

  task automatic check_reset_values();
    chk("rst_inst",       bus.inst,       0);
    chk("rst_inst_valid", bus.inst_valid, 0);
    chk("rst_ld_ready",   bus.ld_ready,   0);
    chk("rst_ld_count",   bus.ld_count,   0);
    chk("rst_ld_done",    bus.ld_done,    0);
    chk("rst_clr_done",   bus.clr_done,   0);
    chk("rst_busy",       bus.busy,       1);
  endtask

  // Count cycles until busy falls; the sweep leaves every word zero.
  task automatic wait_idle(input int want);
    int n = 0;
    int pulses = 0;
    while (bus.busy === 1'b1 && n < 400) begin
      step();
      n++;
      if (bus.clr_done === 1'b1) pulses++;
    end
    step();
    if (bus.clr_done === 1'b1) pulses++;
    chk("clear_cycles", n, want);
    chk("clr_done_pulses", pulses, 1);
    foreach (model[i]) model[i] = '0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    bus.rd_en = 1'b1;
    bus.pc    = a;
    exp_q.push_back(model[a]);
    step();
    bus.rd_en = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) rd(ADDR_W'(i));
    step();
  endtask

  // Stream nwords; the model accepts a word only while a load is open and
  // fewer than DEPTH words have gone in, wrapping the address mod DEPTH.
  task automatic do_load(input logic [ADDR_W-1:0] base, input int nwords,
                         input bit use_last, input int bubble_at);
    int cnt = 0;
    bit active = 1'b1;
    bit ends;
    logic [ADDR_W-1:0] a = base;
    logic [DATA_W-1:0] d;
    bus.ld_base  = base;
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    chk("load_busy", bus.busy, 1);
    for (int i = 0; i < nwords; i++) begin
      if (i == bubble_at) begin
        bus.ld_valid = 1'b0;
        step();
        chk("ld_done_bubble", bus.ld_done, 0);
      end
      d = $urandom;
      if (i == 0) wa = d;
      if (i == 1) wb = d;
      if (i == 2) wc = d;
      bus.ld_valid = 1'b1;
      bus.ld_data  = d;
      bus.ld_last  = use_last && (i == nwords - 1);
      chk("ld_ready", bus.ld_ready, (active && cnt < DEPTH) ? 1 : 0);
      ends = 1'b0;
      if (active) begin
        model[a] = d;
        a = a + 1'b1;
        cnt++;
        if (bus.ld_last || cnt == DEPTH) begin
          active = 1'b0;
          ends = 1'b1;
        end
      end
      step();
      chk("ld_done", bus.ld_done, ends);
      if (ends) chk("load_exit_busy", bus.busy, 0);
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    chk("ld_count", bus.ld_count, cnt);
  endtask

  // Monitor: every presented fetch word is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && bus.inst_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_inst_valid", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("inst", bus.inst, mon_exp);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d;
    drive_idle();
    foreach (model[i]) model[i] = '0;

    // Reset state, then the power-on sweep.
    #12;
    check_reset_values();
    step();
    rst = 1'b0;
    wait_idle(DEPTH);
    read_all();

    // Load three words at base 5 with one bubble, then fetch.
    do_load(7'd5, 3, 1'b1, 1);
    chk("ld_count_3", bus.ld_count, 3);
    rd(7'd7);
    chk("ld_done_single", bus.ld_done, 0);
    chk("model_c", model[7], wc);
    rd(7'd5);
    rd(7'd6);
    rd(7'd8);
    step();

    // Retire and read of the same address in one cycle: old data, then NOP.
    bus.retire      = 1'b1;
    bus.retire_addr = 7'd6;
    rd(7'd6);
    bus.retire = 1'b0;
    model[6] = NOP;
    rd(7'd6);
    step();

    // Retire and read during LOAD are both ignored.
    bus.ld_base  = 7'd20;
    bus.ld_start = 1'b1;
    step();
    bus.ld_start    = 1'b0;
    bus.retire      = 1'b1;
    bus.retire_addr = 7'd5;
    bus.rd_en       = 1'b1;
    bus.pc          = 7'd5;
    step();
    chk("load_rd_blocked", bus.inst_valid, 0);
    bus.retire   = 1'b0;
    bus.rd_en    = 1'b0;
    d            = $urandom;
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = 1'b1;
    model[20]    = d;
    step();
    chk("single_ld_done", bus.ld_done, 1);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    rd(7'd5);
    rd(7'd20);
    step();

    // Wrap from 126 and fill: only DEPTH of 130 words land.
    do_load(7'd126, 130, 1'b0, -1);
    chk("ld_count_full", bus.ld_count, DEPTH);
    read_all();

    // Clear beats load in the same cycle; reads blocked while clearing.
    bus.clr_start = 1'b1;
    bus.ld_start  = 1'b1;
    bus.ld_base   = 7'd3;
    step();
    bus.clr_start = 1'b0;
    bus.ld_start  = 1'b0;
    chk("prio_busy", bus.busy, 1);
    chk("prio_not_load", bus.ld_ready, 0);
    bus.rd_en = 1'b1;
    bus.pc    = ADDR_W'($urandom_range(0, DEPTH-1));
    step();
    bus.rd_en = 1'b0;
    chk("clear_rd_blocked", bus.inst_valid, 0);
    wait_idle(DEPTH - 1);
    chk("ld_count_hold", bus.ld_count, DEPTH);
    for (int i = 0; i < 8; i++) rd(ADDR_W'($urandom_range(0, DEPTH-1)));
    step();

    // Reset in the middle of a load: two words in, third pending.
    d = $urandom | 32'h1;
    bus.retire = 1'b0;
    do_load(7'd40, 1, 1'b1, -1);
    model[40] = bus.ld_data;
    rd(7'd40);
    step();
    bus.ld_base  = 7'd60;
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = d + DATA_W'(i);
      step();
    end
    bus.ld_data = d + 32'd2;
    #3;
    rst = 1'b1;
    #1;
    check_reset_values();
    bus.ld_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    wait_idle(DEPTH);
    read_all();

    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_mem.md
# prog_mem

Parametrised instruction memory that sits between the host loader and the core's fetch stage. It provides:
- a valid/ready streaming load port with auto-incrementing address;
- a hardware clear sweep that runs on reset and on request;
- a registered fetch read port;
- a retire port that overwrites a consumed instruction with a NOP word.

A three-state controller serialises clear, load and normal operation.

## Interface
- DATA_W, 32, instruction word width
- DEPTH, 128, number of words (power of two, ≥ 4)
- ADDR_W, $clog2(DEPTH), address width
- NOP_WORD, 32'h00001013, value written on retire
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clr_start  in  1  pulse: request clear sweep
- ld_start  in  1  pulse: begin load at ld_base
- ld_base  in  ADDR_W  first load address
- ld_valid  in  1  load word valid
- ld_data  in  DATA_W  load word
- ld_last  in  1  final word of load, qualified by ld_valid
- ld_ready  out  1  load word accepted when ld_valid & ld_ready
- ld_count  out  ADDR_W+1  words written by current/last load
- ld_done  out  1  one-cycle pulse, load finished
- clr_done  out  1  one-cycle pulse, clear finished
- busy  out  1  state ≠ IDLE
- rd_en  in  1  fetch request
- pc  in  ADDR_W  fetch address
- inst  out  DATA_W  fetched word, registered
- inst_valid  out  1  inst updated this cycle
- retire  in  1  overwrite mem[retire_addr] with NOP_WORD
- retire_addr  in  ADDR_W  retire address

## Operation
- The memory array has no reset. Contents are defined only by the clear sweep.
- **States:** CLEAR, LOAD, IDLE. Reset forces CLEAR with clr_idx=0.
- **CLEAR:**
  - Each cycle writes 0 to mem[clr_idx], then clr_idx++.
  - After the write to index DEPTH-1, go to IDLE.
  - All starts, retires and reads are ignored.
- **IDLE:**
  - clr_start → CLEAR (clr_idx=0).
  - Else ld_start → LOAD, with waddr=ld_base and ld_count=0.
  - clr_start wins over ld_start in the same cycle.
  - retire writes NOP_WORD to mem[retire_addr].
- **LOAD:**
  - ld_ready = (state==LOAD) & (ld_count<DEPTH). It is combinational from state and count.
  - On each transfer: mem[waddr]<=ld_data, waddr wraps mod DEPTH, ld_count++.
  - Exit to IDLE after the transfer carrying ld_last, or after the transfer that makes ld_count==DEPTH.
  - Starts and retire are ignored.
- **ld_count:** holds its value after LOAD until the next ld_start. It never exceeds DEPTH.
- **Read port:**
  - When rd_en & state==IDLE: inst<=mem[pc] and inst_valid<=1.
  - Otherwise inst_valid<=0 and inst holds its value.
- **Same-cycle retire and read to the same address:** the read returns the old data; the NOP is visible from the next read.
- **Mid-operation reset:** async reset aborts any state immediately. A partial load remains partially written until the sweep overwrites it.

## Timing
- **Reset values:**
  - inst=0, inst_valid=0
  - ld_ready=0, ld_count=0
  - ld_done=0, clr_done=0
  - busy=1 (state CLEAR)
- **Clear:** takes DEPTH cycles. The first write is on the first rising edge after rst deasserts. clr_done=1 and busy=0 in the first IDLE cycle.
- **Start latency:** ld_start sampled at edge t gives LOAD and ld_ready=1 from t+1. The first transfer can occur at edge t+1.
- **Load exit:** final transfer at edge u gives IDLE, busy=0 and ld_done=1 during cycle u..u+1. A read issued in that cycle sees the loaded data.
- **Read latency:** 1 cycle. rd_en at edge t gives inst/inst_valid valid after edge t.
- **Retire:** takes effect at the edge it is sampled. One write per cycle maximum.

## Test plan
- **Reset sweep:** release rst, count cycles. Required: busy high for exactly 128 cycles, clr_done single pulse, then rd_en at pc=0..127 returns 0 for all words.
- **Load and fetch:**
  - ld_start with ld_base=5, then 3 words A,B,C (C with ld_last). Insert one ld_valid bubble.
  - Required: ld_count=3, ld_done pulse one cycle after C.
  - Reads pc=5,6,7 return A,B,C one cycle after rd_en; pc=8 returns 0.
- **Wrap and full:**
  - ld_base=126, stream 130 words with no ld_last.
  - Required: words written at 126,127,0..125; ld_ready drops after word 128; ld_count=128; words 129–130 not accepted.
- **Retire:**
  - Retire pc=6 while reading pc=6 in the same cycle: read returns B.
  - The next read returns 32'h00001013.
  - Retire during LOAD: no change.
- **Priority and blocking:**
  - clr_start and ld_start in the same IDLE cycle: CLEAR entered.
  - rd_en during CLEAR or LOAD: inst_valid stays 0.
- **Mid-load reset:** assert rst after 2 of 5 words. Required: outputs at reset values immediately, full sweep follows, all words read 0.
